sr_ctrl: RTL

SR_CTRL -- requirements
Module: sr_ctrl

---
 rtl/sr_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/sr_ctrl.sv
// sr_ctrl: sequencing and handshake controller for an external DEPTH-tap
// delay line. Samples enter on s_*, leave on m_* exactly DEPTH shifts later.
// Optional feature macro: SR_CTRL_DRAIN_EN adds drain_req and the DRAIN state,
// which flushes the line contents out on m_* before clearing.
//
// state | meaning
// ------+-------------------------------------------------------------
// CLEAR | one-cycle clear pulse to the delay line, no handshakes
// FILL  | accepting samples until DEPTH taps are loaded, no output
// RUN   | one in, one out, lock-step with downstream
// DRAIN | emit remaining taps (zeros shifted in), then CLEAR
module sr_ctrl #(
    parameter int SIG_WIDTH = 16,
    parameter int DEPTH     = 515,
    parameter int CNT_W     = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
`ifdef SR_CTRL_DRAIN_EN
    input  logic                 drain_req,
`endif
    input  logic [SIG_WIDTH-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [SIG_WIDTH-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 sr_en,
    output logic                 sr_clr,
    output logic [SIG_WIDTH-1:0] sr_din,
    input  logic [SIG_WIDTH-1:0] sr_dout,
    output logic [CNT_W-1:0]     fill_cnt,
    output logic [1:0]           state
);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
    logic             sr_clr_q, sr_clr_d;
    logic             drain_act;

`ifdef SR_CTRL_DRAIN_EN
    assign drain_act = drain_req;
`else
    assign drain_act = 1'b0;
`endif

    assign m_data   = sr_dout;
    assign sr_clr   = sr_clr_q;
    assign fill_cnt = fill_cnt_q;
    assign state    = state_q;

    // Handshake and shift-enable decode from the current state; held quiet while in reset.
    always_comb begin
        s_ready = 1'b0;
        m_valid = 1'b0;
        sr_en   = 1'b0;
        sr_din  = s_data;
        case (state_q)
            ST_FILL: begin
                s_ready = 1'b1;
                sr_en   = s_valid;
            end
            ST_RUN: begin
                s_ready = m_ready;
                m_valid = s_valid;
                sr_en   = s_valid & m_ready;
            end
`ifdef SR_CTRL_DRAIN_EN
            ST_DRAIN: begin
                m_valid = 1'b1;
                sr_en   = m_ready;
                sr_din  = '0;
            end
`endif
            default: begin
                s_ready = 1'b0;
            end
        endcase
        if (!rst_n) begin
            s_ready = 1'b0;
            m_valid = 1'b0;
            sr_en   = 1'b0;
        end
    end

    // Next-state and fill-count logic; flush overrides every other transition.
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                state_d    = ST_FILL;
                fill_cnt_d = '0;
            end
            ST_FILL: begin
                if (drain_act) begin
                    state_d    = ST_CLEAR;
                    fill_cnt_d = '0;
                end else if (s_valid) begin
                    fill_cnt_d = fill_cnt_q + ONE_C;
                    if (fill_cnt_q + ONE_C == DEPTH_C) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (drain_act) begin
                    state_d = ST_DRAIN;
                end
            end
`ifdef SR_CTRL_DRAIN_EN
            ST_DRAIN: begin
                if (m_ready) begin
                    fill_cnt_d = fill_cnt_q - ONE_C;
                    if (fill_cnt_q == ONE_C) begin
                        state_d = ST_CLEAR;
                    end
                end
            end
`endif
            default: begin
                state_d    = ST_CLEAR;
                fill_cnt_d = '0;
            end
        endcase
        if (flush) begin
            state_d    = ST_CLEAR;
            fill_cnt_d = '0;
        end
        // The clear strobe is a flop so the delay line sees a glitch-free pulse.
        sr_clr_d = (state_d == ST_CLEAR);
    end

    // State registers; reset lands directly in FILL since the delay line shares rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FILL;
            fill_cnt_q <= '0;
            sr_clr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            sr_clr_q   <= sr_clr_d;
        end
    end

endmodule
